// File: rtl/hazard_control_unit.sv
// rtl/hazard_control_unit.sv - pipeline stall/flush controller for load-use, branch-in-ID, MDU and taken-branch hazards
module hazard_control_unit #(
    parameter int MDU_LATENCY = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        id_valid,
    input  logic [3:0]  id_op1,
    input  logic [3:0]  id_op2,
    input  logic        id_is_branch,
    input  logic        branch_taken,
    input  logic [3:0]  ex_op1,
    input  logic [1:0]  ex_regwrite,
    input  logic        ex_memread,
    input  logic        ex_is_mdu,
    output logic        pc_stall,
    output logic        if_id_stall,
    output logic        id_ex_bubble,
    output logic        if_id_flush,
    output logic        ex_hold,
    output logic        mdu_busy,
    output logic [15:0] stall_cycles
);

    localparam logic [1:0] ST_RUN         = 2'd0;
    localparam logic [1:0] ST_BRANCH_WAIT = 2'd1;
    localparam logic [1:0] ST_MDU_WAIT    = 2'd2;

    // The start cycle in RUN is the first hold cycle, so the wait state covers
    // MDU_LATENCY-2 more; cnt counts the ones left after the current one.
    localparam int         WAIT_INIT      = (MDU_LATENCY > 2) ? MDU_LATENCY - 3 : 0;
    localparam logic [3:0] CNT_LOAD       = 4'(WAIT_INIT);
    localparam logic       MDU_STALLS     = (MDU_LATENCY > 1);
    localparam logic       MDU_NEEDS_WAIT = (MDU_LATENCY > 2);

    logic [1:0]  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        mdu_ack_q, mdu_ack_d;
    logic [15:0] stall_cycles_q, stall_cycles_d;

    logic mdu_start, ld_hit, br_ld, br_alu;
    logic stall_c, bubble_c, flush_c, hold_c;

    assign mdu_start = ex_is_mdu & ~mdu_ack_q & MDU_STALLS;
    assign ld_hit    = id_valid & ex_memread & ((ex_op1 == id_op1) | (ex_op1 == id_op2));
    assign br_ld     = id_valid & id_is_branch & ex_memread & (ex_op1 == id_op1);
    assign br_alu    = id_valid & id_is_branch & ~ex_memread & (ex_regwrite == 2'b11)
                       & (ex_op1 == id_op1);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        mdu_ack_d = mdu_ack_q;
        stall_c   = 1'b0;
        bubble_c  = 1'b0;
        flush_c   = 1'b0;
        hold_c    = 1'b0;
        case (state_q)
            ST_RUN: begin
                mdu_ack_d = 1'b0;
                if (mdu_start) begin
                    stall_c = 1'b1;
                    hold_c  = 1'b1;
                    if (MDU_NEEDS_WAIT) begin
                        state_d = ST_MDU_WAIT;
                        cnt_d   = CNT_LOAD;
                    end else begin
                        mdu_ack_d = 1'b1;
                    end
                end else if (br_ld) begin
                    stall_c  = 1'b1;
                    bubble_c = 1'b1;
                    state_d  = ST_BRANCH_WAIT;
                end else if (ld_hit | br_alu) begin
                    stall_c  = 1'b1;
                    bubble_c = 1'b1;
                end else if (id_valid & id_is_branch & branch_taken) begin
                    flush_c = 1'b1;
                end
            end
            ST_BRANCH_WAIT: begin
                stall_c  = 1'b1;
                bubble_c = 1'b1;
                state_d  = ST_RUN;
            end
            ST_MDU_WAIT: begin
                stall_c = 1'b1;
                hold_c  = 1'b1;
                if (cnt_q == 4'd0) begin
                    state_d   = ST_RUN;
                    mdu_ack_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = ST_RUN;
        endcase
        stall_cycles_d = stall_cycles_q;
        if (stall_c && !rst && stall_cycles_q != 16'hFFFF) begin
            stall_cycles_d = stall_cycles_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= ST_RUN;
            cnt_q          <= 4'd0;
            mdu_ack_q      <= 1'b0;
            stall_cycles_q <= 16'd0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            mdu_ack_q      <= mdu_ack_d;
            stall_cycles_q <= stall_cycles_d;
        end
    end

    // Combinational outputs are forced low while reset is held.
    assign pc_stall     = stall_c & ~rst;
    assign if_id_stall  = stall_c & ~rst;
    assign id_ex_bubble = bubble_c & ~rst;
    assign if_id_flush  = flush_c & ~rst;
    assign ex_hold      = hold_c & ~rst;
    assign mdu_busy     = hold_c & ~rst;
    assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_hazard_control_unit.sv
// tb/tb_hazard_control_unit.sv - self-checking bench for hazard_control_unit
module tb_hazard_control_unit;

    localparam int LAT = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid, id_is_branch, branch_taken, ex_memread, ex_is_mdu;
    logic [3:0]  id_op1, id_op2, ex_op1;
    logic [1:0]  ex_regwrite;
    logic        pc_stall, if_id_stall, id_ex_bubble, if_id_flush, ex_hold, mdu_busy;
    logic [15:0] stall_cycles;

    int checks = 0;
    int errors = 0;

    hazard_control_unit #(.MDU_LATENCY(LAT)) dut (
        .clk(clk), .rst(rst),
        .id_valid(id_valid), .id_op1(id_op1), .id_op2(id_op2),
        .id_is_branch(id_is_branch), .branch_taken(branch_taken),
        .ex_op1(ex_op1), .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
        .ex_is_mdu(ex_is_mdu),
        .pc_stall(pc_stall), .if_id_stall(if_id_stall), .id_ex_bubble(id_ex_bubble),
        .if_id_flush(if_id_flush), .ex_hold(ex_hold), .mdu_busy(mdu_busy),
        .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, got, exp);
        end
    endtask

    // Model: how many forced-stall cycles each hazard class still owes.
    int  m_mdu_left = 0;
    int  m_br_left  = 0;
    bit  m_mdu_done = 0;
    int  m_count    = 0;
    bit  model_on   = 1;

    always @(negedge clk) begin
        bit e_stall, e_bub, e_flush, e_hold, served;
        e_stall = 0; e_bub = 0; e_flush = 0; e_hold = 0;
        if (rst) begin
            m_mdu_left = 0; m_br_left = 0; m_mdu_done = 0; m_count = 0;
        end else if (m_mdu_left > 0) begin
            e_stall = 1; e_hold = 1;
            m_mdu_left--;
            if (m_mdu_left == 0) m_mdu_done = 1;
        end else if (m_br_left > 0) begin
            e_stall = 1; e_bub = 1;
            m_br_left--;
        end else begin
            served = m_mdu_done;
            m_mdu_done = 0;
            if (ex_is_mdu && !served && LAT > 1) begin
                e_stall = 1; e_hold = 1;
                m_mdu_left = LAT - 2;
                if (m_mdu_left == 0) m_mdu_done = 1;
            end else if (id_valid && id_is_branch && ex_memread && ex_op1 == id_op1) begin
                e_stall = 1; e_bub = 1; m_br_left = 1;
            end else if (id_valid && ex_memread && (ex_op1 == id_op1 || ex_op1 == id_op2)) begin
                e_stall = 1; e_bub = 1;
            end else if (id_valid && id_is_branch && ex_regwrite == 2'b11 && ex_op1 == id_op1) begin
                e_stall = 1; e_bub = 1;
            end else if (id_valid && id_is_branch && branch_taken) begin
                e_flush = 1;
            end
        end
        if (model_on) begin
            check("pc_stall", int'(pc_stall), int'(e_stall));
            check("if_id_stall", int'(if_id_stall), int'(e_stall));
            check("id_ex_bubble", int'(id_ex_bubble), int'(e_bub));
            check("if_id_flush", int'(if_id_flush), int'(e_flush));
            check("ex_hold", int'(ex_hold), int'(e_hold));
            check("mdu_busy", int'(mdu_busy), int'(e_hold));
            check("stall_cycles", int'(stall_cycles), m_count);
        end
        if (e_stall && m_count < 65535) m_count++;
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        id_valid = 0; id_is_branch = 0; branch_taken = 0; ex_memread = 0;
        ex_is_mdu = 0; id_op1 = 0; id_op2 = 0; ex_op1 = 0; ex_regwrite = 0;
    endtask

    initial begin
        rst = 1;
        clear_inputs();
        id_op1 = 4'd1; ex_op1 = 4'd1; ex_memread = 1; id_valid = 1;
        mid();
        check("rst_pc_stall", int'(pc_stall), 0);
        check("rst_bubble", int'(id_ex_bubble), 0);
        check("rst_count", int'(stall_cycles), 0);
        next_cycle();
        rst = 0;
        clear_inputs();
        next_cycle();

        // Load-use
        id_valid = 1; ex_memread = 1; ex_op1 = 4'd3; id_op2 = 4'd3; id_op1 = 4'd7;
        mid();
        check("lu_stall", int'(pc_stall), 1);
        check("lu_bubble", int'(id_ex_bubble), 1);
        next_cycle();
        ex_memread = 0;
        mid();
        check("lu_release", int'(pc_stall), 0);
        check("lu_count", int'(stall_cycles), 1);
        next_cycle();
        clear_inputs();
        next_cycle();

        // Branch on load result
        id_valid = 1; id_is_branch = 1; id_op1 = 4'd5; ex_memread = 1; ex_op1 = 4'd5;
        mid();
        check("bl_stall1", int'(pc_stall), 1);
        next_cycle();
        branch_taken = 1;
        mid();
        check("bl_bubble2", int'(id_ex_bubble), 1);
        check("bl_noflush2", int'(if_id_flush), 0);
        next_cycle();
        ex_memread = 0;
        mid();
        check("bl_flush3", int'(if_id_flush), 1);
        check("bl_count", int'(stall_cycles), 3);
        next_cycle();
        clear_inputs();
        next_cycle();

        // Branch on ALU result; a partial regwrite code must not match
        id_valid = 1; id_is_branch = 1; id_op1 = 4'd6; ex_op1 = 4'd6; ex_regwrite = 2'b01;
        mid();
        check("ba_rw01", int'(pc_stall), 0);
        next_cycle();
        ex_regwrite = 2'b11;
        mid();
        check("ba_stall", int'(pc_stall), 1);
        next_cycle();
        ex_regwrite = 2'b00; branch_taken = 1;
        mid();
        check("ba_flush", int'(if_id_flush), 1);
        check("ba_count", int'(stall_cycles), 4);
        next_cycle();
        clear_inputs();
        next_cycle();

        // MDU occupying EX
        ex_is_mdu = 1;
        for (int i = 1; i <= LAT; i++) begin
            mid();
            check($sformatf("mdu_hold_c%0d", i), int'(ex_hold), (i < LAT) ? 1 : 0);
            next_cycle();
        end
        ex_is_mdu = 0;
        mid();
        check("mdu_count", int'(stall_cycles), 7);
        next_cycle();

        // MDU start outranks a simultaneous branch-on-load
        ex_is_mdu = 1; ex_memread = 1; ex_op1 = 4'd2; id_op1 = 4'd2;
        id_valid = 1; id_is_branch = 1; branch_taken = 1;
        mid();
        check("pri_hold", int'(ex_hold), 1);
        check("pri_bubble", int'(id_ex_bubble), 0);
        check("pri_flush", int'(if_id_flush), 0);
        for (int i = 0; i < 5; i++) next_cycle();
        clear_inputs();
        next_cycle();

        // Reset during MDU wait
        ex_is_mdu = 1;
        next_cycle();
        rst = 1;
        mid();
        check("rw_hold", int'(ex_hold), 0);
        check("rw_stall", int'(pc_stall), 0);
        check("rw_count", int'(stall_cycles), 0);
        next_cycle();
        rst = 0;
        for (int i = 1; i <= LAT; i++) begin
            mid();
            check($sformatf("rw_hold_c%0d", i), int'(ex_hold), (i < LAT) ? 1 : 0);
            next_cycle();
        end
        clear_inputs();
        next_cycle();

        // Counter saturation
        rst = 1;
        next_cycle();
        rst = 0;
        id_valid = 1; ex_memread = 1; ex_op1 = 4'd9; id_op1 = 4'd9;
        for (int i = 0; i < 70000; i++) next_cycle();
        mid();
        check("sat_count", int'(stall_cycles), 65535);
        next_cycle();
        next_cycle();
        mid();
        check("sat_hold", int'(stall_cycles), 65535);
        model_on = 0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
